// File: rtl/fcp_pkg.sv
// Shared constants, FSM state encoding and small helpers for the FCP
// master-side transaction scheduler.
package fcp_pkg;

  localparam logic [7:0] SBRWR    = 8'h0B;
  localparam logic [7:0] SBRRD    = 8'h0C;
  localparam logic [7:0] FCP_ACK  = 8'h08;
  localparam logic [7:0] FCP_NACK = 8'h03;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_CMD  = 3'd1,
    TX_ADDR = 3'd2,
    TX_DATA = 3'd3,
    WAIT_RX = 3'd4,
    GAP     = 3'd5,
    RESP    = 3'd6
  } state_t;

  // Command byte that opens a frame.
  function automatic logic [7:0] cmd_byte(input logic wr);
    return wr ? SBRWR : SBRRD;
  endfunction

  // One-hot requester vector from a requester index.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fcp_rr_arb2.sv
// Two-way round-robin arbiter. rr_last holds the most recent winner; on a
// tie the other requester wins. Reset leaves rr_last=1 so requester 0 wins
// the first tie.
module fcp_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  logic r_rr_last;

  // Combinational one-hot grant from the current requests and rr_last.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_rr_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember the winner whenever the scheduler actually takes a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= 1'b1;
    end else if (i_take) begin
      r_rr_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/fcp_xfer_sched.sv
// FCP master transaction scheduler: arbitrates two requesters onto one
// byte-level PHY, sends SBRWR/SBRRD frames, checks the slave reply, retries
// after an idle gap and returns a one-cycle response to the owner.
// One 16-bit counter serves both as reply timeout and as retry gap timer.
module fcp_xfer_sched
  import fcp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000,
  parameter int GAP_CYC     = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_perr,
  output logic        busy
);

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_retry;
  logic        r_owner;
  logic        r_wr;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [1:0]  r_req_ready;
  logic [1:0]  r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_tx_valid;
  logic [7:0]  r_tx_byte;
  logic        r_busy;

  logic [1:0]  w_grant;
  logic        w_take;
  logic        w_gnt_id;
  logic        w_rx_ok;
  logic        w_fail;

  fcp_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  // Grant qualification and reply classification for the current cycle.
  always_comb begin
    w_take   = 1'b0;
    w_gnt_id = w_grant[1];
    w_rx_ok  = 1'b0;
    w_fail   = 1'b0;
    if (r_state == IDLE) begin
      w_take = (w_grant != 2'b00);
    end else begin
      w_take = 1'b0;
    end
    if (r_state == WAIT_RX) begin
      // A reply on the final timeout cycle still counts: rx_valid wins.
      w_rx_ok = rx_valid && !rx_perr && (!r_wr || (rx_byte == FCP_ACK));
      if (rx_valid) begin
        w_fail = !w_rx_ok;
      end else begin
        w_fail = (r_cnt == TO_LAST);
      end
    end else begin
      w_rx_ok = 1'b0;
      w_fail  = 1'b0;
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_retry     <= 4'd0;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_req_ready <= w_grant;
            r_owner     <= w_gnt_id;
            r_wr        <= req_wr[w_gnt_id];
            r_addr      <= w_gnt_id ? req_addr[15:8]  : req_addr[7:0];
            r_wdata     <= w_gnt_id ? req_wdata[15:8] : req_wdata[7:0];
            r_retry     <= 4'd0;
            r_busy      <= 1'b1;
            r_tx_valid  <= 1'b1;
            r_tx_byte   <= cmd_byte(req_wr[w_gnt_id]);
            r_state     <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (tx_ready) begin
            r_tx_byte <= r_addr;
            r_state   <= TX_ADDR;
          end
        end
        TX_ADDR: begin
          if (tx_ready) begin
            if (r_wr) begin
              r_tx_byte <= r_wdata;
              r_state   <= TX_DATA;
            end else begin
              r_tx_valid <= 1'b0;
              r_tx_byte  <= 8'h00;
              r_cnt      <= 16'd0;
              r_state    <= WAIT_RX;
            end
          end
        end
        TX_DATA: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_cnt      <= 16'd0;
            r_state    <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (w_rx_ok) begin
            r_rsp_valid <= onehot2(r_owner);
            r_rsp_rdata <= r_wr ? 8'h00 : rx_byte;
            r_rsp_err   <= 1'b0;
            r_state     <= RESP;
          end else if (w_fail) begin
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 4'd1;
              r_cnt   <= 16'd0;
              r_state <= GAP;
            end else begin
              r_rsp_valid <= onehot2(r_owner);
              r_rsp_rdata <= 8'h00;
              r_rsp_err   <= 1'b1;
              r_state     <= RESP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt      <= 16'd0;
            r_tx_valid <= 1'b1;
            r_tx_byte  <= cmd_byte(r_wr);
            r_state    <= TX_CMD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          r_rsp_rdata <= 8'h00;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign tx_valid  = r_tx_valid;
  assign tx_byte   = r_tx_byte;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fcp_xfer_sched.sv
// Directed bench for fcp_xfer_sched: table of single transactions plus
// hand-written contention, stray-rx and mid-transaction reset sequences.
module tb_fcp_xfer_sched;

  localparam int T = 200;
  localparam int G = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_perr;
  logic        busy;

  always #5 clk = ~clk;

  fcp_xfer_sched #(.TIMEOUT_CYC(T), .GAP_CYC(G), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_perr(rx_perr),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Event log written at each rising edge.
  int         cyc = 0;
  logic [7:0] tx_b[$];
  int         tx_c[$];
  int         gnt_id[$];
  int         gnt_c[$];
  logic [1:0] rsp_v[$];
  logic [7:0] rsp_d[$];
  logic       rsp_e[$];
  int         rsp_c[$];
  int         both_rdy = 0;

  // Record PHY handshakes, grants and responses with their cycle stamps.
  always @(posedge clk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      tx_b.push_back(tx_byte);
      tx_c.push_back(cyc);
    end
    if (req_ready === 2'b11) both_rdy++;
    if (req_ready === 2'b01) begin gnt_id.push_back(0); gnt_c.push_back(cyc); end
    if (req_ready === 2'b10) begin gnt_id.push_back(1); gnt_c.push_back(cyc); end
    if (rsp_valid === 2'b01 || rsp_valid === 2'b10 || rsp_valid === 2'b11) begin
      rsp_v.push_back(rsp_valid);
      rsp_d.push_back(rsp_rdata);
      rsp_e.push_back(rsp_err);
      rsp_c.push_back(cyc);
    end
    cyc++;
  end

  typedef struct {
    int         id;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         dly;
    logic [7:0] rbyte;
    int         n_perr;
    bit         silent;
    int         exp_frames;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    tx_b.delete(); tx_c.delete(); gnt_id.delete(); gnt_c.delete();
    rsp_v.delete(); rsp_d.delete(); rsp_e.delete(); rsp_c.delete();
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (tx_b.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_gnt(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt_id.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_v.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic perr);
    rx_valid = 1'b1; rx_byte = b; rx_perr = perr;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte = 8'h00; rx_perr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int flen;
    bit ok;
    int fail_d[4];
    logic [7:0] ef[3];
    flen = v.wr ? 3 : 2;
    ef[0] = v.wr ? 8'h0B : 8'h0C;
    ef[1] = v.addr;
    ef[2] = v.wdata;
    @(negedge clk);
    clear_log();
    req_wr[v.id] = v.wr;
    if (v.id == 0) begin req_addr[7:0] = v.addr; req_wdata[7:0] = v.wdata; end
    else begin req_addr[15:8] = v.addr; req_wdata[15:8] = v.wdata; end
    req_valid[v.id] = 1'b1;
    wait_gnt(1, ok);
    chk("grant_seen", 32'(ok), 32'd1);
    if (!ok) begin req_valid = 2'b00; return; end
    chk("grant_id", 32'(gnt_id[0]), 32'(v.id));
    chk("busy_after_grant", 32'(busy), 32'd1);
    // Drop the request and scramble its fields: only grant-time values count.
    req_valid[v.id] = 1'b0;
    req_wr = ~req_wr;
    req_addr = ~req_addr;
    req_wdata = ~req_wdata;
    for (int a = 0; a < v.exp_frames; a++) begin
      wait_tx((a + 1) * flen, ok);
      chk("frame_arrived", 32'(ok), 32'd1);
      if (!ok) break;
      if (a < v.n_perr) begin
        repeat (v.dly) @(negedge clk);
        pulse_rx(v.rbyte, 1'b1);
        fail_d[a] = v.dly + G + 2;
      end else if (v.silent) begin
        fail_d[a] = T + G + 1;
      end else begin
        repeat (v.dly) @(negedge clk);
        pulse_rx(v.rbyte, 1'b0);
        fail_d[a] = v.dly + G + 2;
      end
    end
    wait_rsp(1, ok);
    chk("rsp_seen", 32'(ok), 32'd1);
    if (!ok) return;
    repeat (3) @(negedge clk);
    chk("rsp_count", 32'(rsp_v.size()), 32'd1);
    chk("rsp_owner", 32'(rsp_v[0]), (v.id == 1) ? 32'd2 : 32'd1);
    chk("rsp_rdata", 32'(rsp_d[0]), 32'(v.exp_rdata));
    chk("rsp_err", 32'(rsp_e[0]), 32'(v.exp_err));
    chk("busy_after_rsp", 32'(busy), 32'd0);
    chk("tx_byte_count", 32'(tx_b.size()), 32'(v.exp_frames * flen));
    if (tx_b.size() == v.exp_frames * flen) begin
      for (int a = 0; a < v.exp_frames; a++) begin
        for (int k = 0; k < flen; k++) chk("tx_byte", 32'(tx_b[a * flen + k]), 32'(ef[k]));
        if (a > 0) chk("resend_gap", 32'(tx_c[a * flen] - tx_c[a * flen - 1]), 32'(fail_d[a - 1]));
      end
    end
    if (v.exp_frames == 1) chk("grant_to_rsp", 32'(rsp_c[0] - gnt_c[0]), 32'(flen + 1 + v.dly));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vec_t vr;
    int txn;
    vecs[0] = '{0, 1'b1, 8'h2C, 8'h5A, 100,   8'h08, 0, 1'b0, 1, 8'h00, 1'b0};
    vecs[1] = '{1, 1'b0, 8'h01, 8'h00, 3,     8'h91, 0, 1'b0, 1, 8'h91, 1'b0};
    vecs[2] = '{0, 1'b1, 8'h10, 8'h33, 5,     8'h08, 2, 1'b0, 3, 8'h00, 1'b0};
    vecs[3] = '{1, 1'b1, 8'h20, 8'h44, 0,     8'h00, 0, 1'b1, 4, 8'h00, 1'b1};
    vecs[4] = '{0, 1'b0, 8'h05, 8'h00, T - 1, 8'h7E, 0, 1'b0, 1, 8'h7E, 1'b0};
    vecs[5] = '{1, 1'b1, 8'h06, 8'h01, 2,     8'h03, 0, 1'b0, 4, 8'h00, 1'b1};
    vecs[6] = '{0, 1'b0, 8'h07, 8'h00, 1,     8'h55, 4, 1'b0, 4, 8'h00, 1'b1};

    rst = 1'b1;
    tx_ready = 1'b1;
    rx_valid = 1'b0; rx_byte = 8'h00; rx_perr = 1'b0;
    // Both requesters valid (reads) while reset is held.
    req_valid = 2'b11; req_wr = 2'b00;
    req_addr = 16'h2211; req_wdata = 16'h0000;
    repeat (4) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_byte, busy}, 32'd0);
    clear_log();
    rst = 1'b0;

    // Contention: expect grants 0,1,0,1 with re-requests after each response.
    txn = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(k + 1, ok);
      chk("cont_grant_seen", 32'(ok), 32'd1);
      if (!ok) break;
      chk("cont_grant_order", 32'(gnt_id[k]), 32'(k % 2));
      req_valid[gnt_id[k]] = 1'b0;
      txn = txn + 2;
      wait_tx(txn, ok);
      if (!ok) begin chk("cont_frame", 32'(ok), 32'd1); break; end
      @(negedge clk);
      pulse_rx(8'hA0 + 8'(k), 1'b0);
      wait_rsp(k + 1, ok);
      if (!ok) begin chk("cont_rsp", 32'(ok), 32'd1); break; end
      chk("cont_rdata", 32'(rsp_d[k]), 32'(8'hA0 + 8'(k)));
      if (k < 2) req_valid[gnt_id[k]] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("cont_no_double_ready", 32'(both_rdy), 32'd0);
    req_valid = 2'b00;

    foreach (vecs[i]) run_vec(vecs[i]);

    // rx_valid while idle is ignored.
    @(negedge clk);
    clear_log();
    pulse_rx(8'h08, 1'b0);
    repeat (5) @(negedge clk);
    chk("idle_rx_no_rsp", 32'(rsp_v.size()), 32'd0);
    chk("idle_rx_not_busy", 32'(busy), 32'd0);

    // Reset in the middle of WAIT_RX.
    clear_log();
    req_wr[0] = 1'b1; req_addr[7:0] = 8'h33; req_wdata[7:0] = 8'h77;
    req_valid[0] = 1'b1;
    wait_gnt(1, ok);
    chk("rstmid_grant", 32'(ok), 32'd1);
    req_valid[0] = 1'b0;
    wait_tx(3, ok);
    chk("rstmid_frame", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    repeat (T + G + 10) @(negedge clk);
    chk("rstmid_no_rsp", 32'(rsp_v.size()), 32'd0);
    chk("rstmid_no_resend", 32'(tx_b.size()), 32'd3);
    vr = '{1, 1'b0, 8'h44, 8'h00, 2, 8'h5C, 0, 1'b0, 1, 8'h5C, 1'b0};
    run_vec(vr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
